// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: bus types, register counts and
// the named enable/reset levels used by the pipeline's write-back and decode.
package regfile_pkg;

    localparam int RegWidth   = 32;
    localparam int RegNum     = 32;
    localparam int RegNumLog2 = 5;

    typedef logic [RegWidth-1:0]   RegBus;
    typedef logic [RegNumLog2-1:0] RegAddrBus;

    localparam RegBus ZeroWord = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;
    localparam logic RstEnable    = 1'b1;

endpackage

// File: rtl/regfile_hilo_reg.sv
// HI/LO special-register pair: loaded together, cleared by reset.
// Same-cycle write-through of hi_i/lo_i when REGFILE_WR_BYPASS_EN is defined.
module hilo_reg
    import regfile_pkg::*;
#(
    parameter int DATA_W = RegWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_d;
    logic [DATA_W-1:0] lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (we == WriteEnable) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Reset masks the outputs combinationally, ahead of any bypass.
    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (rst != RstEnable) begin
`ifdef REGFILE_WR_BYPASS_EN
            if (we == WriteEnable) begin
                hi_o = hi_i;
                lo_o = lo_i;
            end else begin
                hi_o = hi_q;
                lo_o = lo_q;
            end
`else
            hi_o = hi_q;
            lo_o = lo_q;
`endif
        end
    end

endmodule

// File: rtl/regfile.sv
// 2-read / 1-write general-purpose register file with $0 hard-wired to zero,
// plus HI/LO. Optional write-to-read bypass: define REGFILE_WR_BYPASS_EN.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = RegWidth,
    parameter int ADDR_W = RegNumLog2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              hilo_we,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_en_d;
    logic              hit1_d;
    logic              hit2_d;

    // A write to $0 is dropped here so the entry stays at its reset value.
    assign wr_en_d = (we == WriteEnable) && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            regs_q[waddr] <= wdata;
        end
    end

`ifdef REGFILE_WR_BYPASS_EN
    assign hit1_d = wr_en_d && (raddr1 == waddr);
    assign hit2_d = wr_en_d && (raddr2 == waddr);
`else
    assign hit1_d = 1'b0;
    assign hit2_d = 1'b0;
`endif

    always_comb begin
        rdata1 = '0;
        if (rst == RstEnable) begin
            rdata1 = '0;
        end else if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (re1 == ReadDisable) begin
            rdata1 = '0;
        end else if (hit1_d) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst == RstEnable) begin
            rdata2 = '0;
        end else if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (re2 == ReadDisable) begin
            rdata2 = '0;
        end else if (hit2_d) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs_q[raddr2];
        end
    end

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo_reg (
        .clk  (clk),
        .rst  (rst),
        .we   (hilo_we),
        .hi_i (hi_i),
        .lo_i (lo_i),
        .hi_o (hi_o),
        .lo_o (lo_o)
    );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed cases plus a randomised phase
// against a reference model; expectations flow through a queue.
module tb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          re1;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] rdata1;
    logic          re2;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata2;
    logic          hilo_we;
    logic [DW-1:0] hi_i;
    logic [DW-1:0] lo_i;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    int            sel_q[$];
    string         tag_q[$];

    logic [DW-1:0] model [2**AW];
    logic [DW-1:0] m_hi;
    logic [DW-1:0] m_lo;

`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re1     (re1),
        .raddr1  (raddr1),
        .rdata1  (rdata1),
        .re2     (re2),
        .raddr2  (raddr2),
        .rdata2  (rdata2),
        .hilo_we (hilo_we),
        .hi_i    (hi_i),
        .lo_i    (lo_i),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic push(input int sel, input string tag, input logic [DW-1:0] val);
        sel_q.push_back(sel);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    // Let combinational outputs settle, then drain the queue.
    task automatic sample();
        logic [DW-1:0] obs;
        int            sel;
        #1;
        while (exp_q.size() > 0) begin
            sel = sel_q.pop_front();
            case (sel)
                0:       obs = rdata1;
                1:       obs = rdata2;
                2:       obs = hi_o;
                default: obs = lo_o;
            endcase
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        hilo_we = 1'b0; hi_i = '0; lo_i = '0;
    endtask

    // Update the reference model with what this edge should commit, then clock.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) model[i] = '0;
            m_hi = '0;
            m_lo = '0;
        end else begin
            if (we && waddr != '0) model[waddr] = wdata;
            if (hilo_we) begin
                m_hi = hi_i;
                m_lo = lo_i;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle();
        we = 1'b1; waddr = a; wdata = d;
        tick();
        idle();
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic re, input logic [AW-1:0] ra);
        if (rst) return '0;
        if (ra == '0) return '0;
        if (!re) return '0;
        if (BYP && we && ra == waddr) return wdata;
        return model[ra];
    endfunction

    initial begin
        for (int i = 0; i < 2**AW; i++) model[i] = '0;
        m_hi = '0;
        m_lo = '0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        re1 = 1'b1; raddr1 = 5'd5;
        push(0, "post_init_r1", 32'h0);
        push(2, "post_init_hi", 32'h0);
        push(3, "post_init_lo", 32'h0);
        sample();

        // Reset clears stored contents and masks outputs while asserted.
        write(5'd5, 32'h1234_5678);
        re1 = 1'b1; raddr1 = 5'd5;
        push(0, "pre_rst_r5", 32'h1234_5678);
        sample();
        rst = 1'b1;
        we = 1'b1; waddr = 5'd9; wdata = 32'hCAFE_0009;
        push(0, "in_rst_r5", 32'h0);
        sample();
        tick();
        rst = 1'b0;
        idle();
        re1 = 1'b1; raddr1 = 5'd5;
        re2 = 1'b1; raddr2 = 5'd9;
        push(0, "after_rst_r5", 32'h0);
        push(1, "rst_write_dropped_r9", 32'h0);
        push(2, "after_rst_hi", 32'h0);
        push(3, "after_rst_lo", 32'h0);
        sample();

        // $0 never reads back nonzero.
        idle();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0;
        push(0, "r0_same_cycle", 32'h0);
        sample();
        tick();
        re1 = 1'b1; raddr1 = 5'd0;
        push(0, "r0_next_cycle", 32'h0);
        sample();

        // Basic write then read, and read enable gating.
        write(5'd3, 32'hDEAD_BEEF);
        re2 = 1'b1; raddr2 = 5'd3;
        push(1, "r3_read", 32'hDEAD_BEEF);
        sample();
        re2 = 1'b0;
        push(1, "r3_re_off", 32'h0);
        sample();

        // Same-cycle write/read of one register.
        write(5'd7, 32'h1);
        we = 1'b1; waddr = 5'd7; wdata = 32'h2;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
        push(0, "hazard_r1", BYP ? 32'h2 : 32'h1);
        push(1, "hazard_r2", BYP ? 32'h2 : 32'h1);
        sample();
        tick();
        idle();
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
        push(0, "hazard_next_r1", 32'h2);
        push(1, "hazard_next_r2", 32'h2);
        sample();

        // HI/LO load, then a load attempted under reset.
        idle();
        hilo_we = 1'b1; hi_i = 32'hAAAA_0000; lo_i = 32'h0000_5555;
        push(2, "hilo_same_hi", BYP ? 32'hAAAA_0000 : 32'h0);
        push(3, "hilo_same_lo", BYP ? 32'h0000_5555 : 32'h0);
        sample();
        tick();
        idle();
        push(2, "hilo_hi", 32'hAAAA_0000);
        push(3, "hilo_lo", 32'h0000_5555);
        sample();
        rst = 1'b1;
        hilo_we = 1'b1; hi_i = 32'h1357_9BDF; lo_i = 32'h2468_ACE0;
        push(2, "hilo_in_rst_hi", 32'h0);
        push(3, "hilo_in_rst_lo", 32'h0);
        sample();
        tick();
        rst = 1'b0;
        idle();
        push(2, "hilo_rst_hi", 32'h0);
        push(3, "hilo_rst_lo", 32'h0);
        sample();

        // Dual independent ports, addresses swapped in the same cycle.
        write(5'd1, 32'h11);
        write(5'd2, 32'h22);
        re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd2;
        push(0, "dual_r1", 32'h11);
        push(1, "dual_r2", 32'h22);
        sample();
        raddr1 = 5'd2; raddr2 = 5'd1;
        push(0, "swap_r1", 32'h22);
        push(1, "swap_r2", 32'h11);
        sample();

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 49) == 0);
            we      = $urandom_range(0, 1);
            waddr   = AW'($urandom_range(0, 2**AW - 1));
            wdata   = $urandom;
            re1     = ($urandom_range(0, 3) != 0);
            raddr1  = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 2**AW - 1));
            re2     = ($urandom_range(0, 3) != 0);
            raddr2  = ($urandom_range(0, 3) == 0) ? raddr1 : AW'($urandom_range(0, 2**AW - 1));
            hilo_we = ($urandom_range(0, 3) == 0);
            hi_i    = $urandom;
            lo_i    = $urandom;
            push(0, "rand_r1", exp_rd(re1, raddr1));
            push(1, "rand_r2", exp_rd(re2, raddr2));
            push(2, "rand_hi", rst ? 32'h0 : ((BYP && hilo_we) ? hi_i : m_hi));
            push(3, "rand_lo", rst ? 32'h0 : ((BYP && hilo_we) ? lo_i : m_lo));
            sample();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the five-stage pipeline: 32 × 32-bit registers plus the HI/LO special-register pair. It answers the decode stage's two read requests (read enables + addresses) combinationally and takes one write per cycle from write-back, so a write and its dependent read in decode resolve without a stall. Bypass is configurable.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register address width; depth = 2**ADDR_W
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `we`  in  1  GPR write enable from write-back
- `waddr`  in  ADDR_W  GPR write address
- `wdata`  in  DATA_W  GPR write data
- `re1`  in  1  read-port-1 enable from decode
- `raddr1`  in  ADDR_W  read-port-1 address
- `rdata1`  out  DATA_W  read-port-1 data, combinational
- `re2`  in  1  read-port-2 enable
- `raddr2`  in  ADDR_W  read-port-2 address
- `rdata2`  out  DATA_W  read-port-2 data, combinational
- `hilo_we`  in  1  HI/LO write enable (MTHI/MTLO/multiply result from write-back)
- `hi_i`  in  DATA_W  HI write data
- `lo_i`  in  DATA_W  LO write data
- `hi_o`  out  DATA_W  current HI
- `lo_o`  out  DATA_W  current LO

## Operation
- GPR write: at posedge, if `!rst && we && waddr != 0`, `regs[waddr] <= wdata`. Writes to $0 are dropped.
- GPR read, per port, in priority order:
  1. `rst` → 0
  2. `raddr == 0` → 0
  3. `!re` → 0
  4. bypass hit (see Configuration) → `wdata`
  5. otherwise → `regs[raddr]`
- Both ports are independent. Same address on both ports returns identical data.
- HI/LO: at posedge, if `!rst && hilo_we`, HI and LO are loaded together from `hi_i`/`lo_i`. Partial writes are the writer's job: it presents the old value on the untouched half.
- `hi_o`/`lo_o` are register outputs, with bypass per Configuration.

## Timing
- Reset: every GPR, HI and LO clears to 0 on the first rising edge with `rst` high. While `rst` is high, `rdata1`, `rdata2`, `hi_o` and `lo_o` read 0 combinationally.
- A write presented in the same cycle `rst` is high is discarded.
- Read latency 0 cycles (address → data combinational). Write latency 1 edge.
- Without bypass, a value written at edge N is readable from cycle N+1.
- Write while `rst` is deasserted mid-operation: takes effect normally at the next edge. Register contents prior to reset are lost.
- Simultaneous write and read of the same address in one cycle: behaviour per Configuration. Reading $0 always yields 0, even when `we && waddr == 0`.
- There is no handshake. `we`/`hilo_we` are single-cycle strobes, and a held strobe rewrites every cycle.

## Configuration
- `REGFILE_WR_BYPASS_EN` defined:
  - Read port returns `wdata` when `re && we && raddr == waddr && raddr != 0`, same cycle.
  - `hi_o`/`lo_o` return `hi_i`/`lo_i` when `hilo_we`.
  - Covers the three-instruction-apart RAW hazard that decode forwarding does not.
- Undefined:
  - No bypass; reads return stored contents only.
  - The pipeline must not issue a decode-stage read of a register being written back in the same cycle.
- `rst` still overrides bypass in both builds.

## Structure
- Shared defines package holds:
  - bus ranges `RegBus` and `RegAddrBus`
  - `RegNum` (32) and `RegNumLog2` (5)
  - `ZeroWord`
  - `WriteEnable`/`WriteDisable` and `ReadEnable`/`ReadDisable`
  - `RstEnable`
- One sub-module, `hilo_reg`: HI/LO storage, reset, and its own bypass mux. The GPR array and both read muxes stay in `regfile`.

## Test plan
- Reset: write `regs[5] = 0x1234_5678`, assert `rst` one cycle, deassert → `rdata1` at `raddr1 = 5`, `re1 = 1` reads 0x0000_0000; `hi_o = lo_o = 0`.
- $0: `we = 1`, `waddr = 0`, `wdata = 0xFFFF_FFFF`; next cycle `raddr1 = 0`, `re1 = 1` → `rdata1 = 0`. The same-cycle read is also 0 with bypass enabled.
- Write/read: write `regs[3] = 0xDEAD_BEEF` at edge N; cycle N+1 `re2 = 1`, `raddr2 = 3` → `rdata2 = 0xDEAD_BEEF`; `re2 = 0` → 0.
- Same-cycle hazard:
  - Setup: `regs[7] = 0x1`; drive `we = 1`, `waddr = 7`, `wdata = 0x2`; `re1 = re2 = 1`, `raddr1 = raddr2 = 7`.
  - With `REGFILE_WR_BYPASS_EN`: both ports read 0x2.
  - Without: both read 0x1, then 0x2 next cycle.
- HI/LO:
  - `hilo_we = 1`, `hi_i = 0xAAAA_0000`, `lo_i = 0x0000_5555` → after the edge, `hi_o`/`lo_o` hold these values.
  - `hilo_we` asserted together with `rst` → HI/LO stay 0.
- Dual-port: `regs[1] = 0x11`, `regs[2] = 0x22`; `raddr1 = 1`, `raddr2 = 2` → 0x11/0x22. Swap addresses → 0x22/0x11 in the same cycle.
